cacheline_adaptor: RTL and testbench

- Sits directly downstream of the cache arbiter.
- Converts one 256-bit cache-line read or write into a 4-beat, 64-bit burst on the physical memory bus, then returns a one-cycle completion to the arbiter.
- Read data is assembled into a full line and presented alongside the completion.
- Exactly one transaction is outstanding at a time.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/cacheline_adaptor.sv | 90 +++++++++
 tb/tb_cacheline_adaptor.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: cache-line adaptor state, beat index and line geometry.
package rv32i_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int NUM_BEATS   = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_BITS   = $clog2(NUM_BEATS);

  localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_001f;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

  typedef logic [BEAT_BITS-1:0] beat_t;

  function automatic logic [31:0] line_align(
    input logic [31:0] addr
  );
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits one 256-bit line read/write into a 4-beat 64-bit memory burst
// and returns a one-cycle completion strobe to the cache arbiter.
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [31:0]            address_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic                   adaptor_resp,
  output logic [LINE_WIDTH-1:0]  line_resp,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS - 1);

  adaptor_state_t        state;
  beat_t                 k;
  beat_t                 k_next;
  logic [LINE_WIDTH-1:0] line_buf;

  assign k_next = k + beat_t'(1);

  // address_o doubles as the latched line address for the burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      line_buf     <= '0;
      line_resp    <= '0;
      burst_o      <= '0;
      address_o    <= '0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      adaptor_resp <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          adaptor_resp <= 1'b0;
          k            <= '0;
          if (pmem_write) begin
            address_o <= line_align(address_i);
            line_buf  <= line_i;
            burst_o   <= line_i[BURST_WIDTH-1:0];
            write_o   <= 1'b1;
            state     <= WRITE;
          end else if (pmem_read) begin
            address_o <= line_align(address_i);
            read_o    <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_resp[int'(k)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            k <= k_next;
            if (k == LAST_BEAT) begin
              read_o       <= 1'b0;
              adaptor_resp <= 1'b1;
              state        <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            k       <= k_next;
            burst_o <= line_buf[int'(k_next)*BURST_WIDTH +: BURST_WIDTH];
            if (k == LAST_BEAT) begin
              write_o      <= 1'b0;
              adaptor_resp <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          adaptor_resp <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and random bursts
// against a line-level reference model.
module tb_cacheline_adaptor;
  import rv32i_types::*;

  typedef logic [63:0] beats_t [4];
  typedef int gaps_t [4];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pmem_read = 1'b0;
  logic pmem_write = 1'b0;
  logic [31:0] address_i = '0;
  logic [LINE_WIDTH-1:0] line_i = '0;
  logic adaptor_resp;
  logic [LINE_WIDTH-1:0] line_resp;
  logic [BURST_WIDTH-1:0] burst_i = '0;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [31:0] address_o;
  logic read_o;
  logic write_o;
  logic resp_i = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [LINE_WIDTH-1:0] last_line = '0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk),
    .rst(rst),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .address_i(address_i),
    .line_i(line_i),
    .adaptor_resp(adaptor_resp),
    .line_resp(line_resp),
    .burst_i(burst_i),
    .burst_o(burst_o),
    .address_o(address_o),
    .read_o(read_o),
    .write_o(write_o),
    .resp_i(resp_i)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_read(
    input logic [31:0] a,
    input beats_t b,
    input gaps_t g,
    input bit hold
  );
    logic [31:0] ea;
    ea = a & 32'hffff_ffe0;
    @(negedge clk);
    pmem_read = 1'b1;
    pmem_write = 1'b0;
    address_i = a;
    line_i = {8{$urandom}};
    @(negedge clk);
    if (!hold) pmem_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= g[k]; s++) begin
        resp_i = (s == g[k]);
        burst_i = (s == g[k]) ? b[k] : rnd64();
        n_checks++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_strobe beat%0d: rd=%b wr=%b want rd=1 wr=0",
                   k, read_o, write_o);
        end
        n_checks++;
        if (address_o !== ea) begin
          n_fail++;
          $display("FAIL rd_addr: got %h want %h", address_o, ea);
        end
        n_checks++;
        if (adaptor_resp !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_early_resp beat%0d: got %b want 0",
                   k, adaptor_resp);
        end
        @(negedge clk);
      end
    end
    resp_i = 1'b0;
    burst_i = rnd64();
    last_line = {b[3], b[2], b[1], b[0]};
    n_checks++;
    if (adaptor_resp !== 1'b1 || read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_done: resp=%b rd=%b want resp=1 rd=0",
               adaptor_resp, read_o);
    end
    n_checks++;
    if (line_resp !== last_line) begin
      n_fail++;
      $display("FAIL rd_line: got %h want %h", line_resp, last_line);
    end
  endtask

  task automatic run_write(
    input logic [31:0] a,
    input beats_t d,
    input gaps_t g,
    input bit both
  );
    logic [31:0] ea;
    ea = a & 32'hffff_ffe0;
    @(negedge clk);
    pmem_write = 1'b1;
    pmem_read = both;
    address_i = a;
    line_i = {d[3], d[2], d[1], d[0]};
    @(negedge clk);
    pmem_write = 1'b0;
    pmem_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= g[k]; s++) begin
        resp_i = (s == g[k]);
        burst_i = rnd64();
        n_checks++;
        if (write_o !== 1'b1 || read_o !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_strobe beat%0d: wr=%b rd=%b want wr=1 rd=0",
                   k, write_o, read_o);
        end
        n_checks++;
        if (burst_o !== d[k]) begin
          n_fail++;
          $display("FAIL wr_data beat%0d: got %h want %h",
                   k, burst_o, d[k]);
        end
        n_checks++;
        if (address_o !== ea) begin
          n_fail++;
          $display("FAIL wr_addr: got %h want %h", address_o, ea);
        end
        n_checks++;
        if (adaptor_resp !== 1'b0 || line_resp !== last_line) begin
          n_fail++;
          $display("FAIL wr_side: resp=%b line_resp=%h want resp=0 line=%h",
                   adaptor_resp, line_resp, last_line);
        end
        @(negedge clk);
      end
    end
    resp_i = 1'b0;
    n_checks++;
    if (adaptor_resp !== 1'b1 || write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: resp=%b wr=%b want resp=1 wr=0",
               adaptor_resp, write_o);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || adaptor_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: rd=%b wr=%b resp=%b want 0",
               read_o, write_o, adaptor_resp);
    end
    n_checks++;
    if (address_o !== '0 || burst_o !== '0 || line_resp !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h burst=%h line=%h want 0",
               address_o, burst_o, line_resp);
    end
    @(negedge clk);
    rst = 1'b0;
    last_line = '0;
  endtask

  task automatic test_read_b2b();
    beats_t b;
    gaps_t g;
    b = '{{8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}};
    g = '{0, 0, 0, 0};
    run_read(32'h0000_1234, b, g, 1'b0);
  endtask

  task automatic test_write();
    beats_t d;
    gaps_t g;
    d = '{64'hd0d0_0000_0000_00d0, 64'hd1d1_1111_1111_11d1,
          64'hd2d2_2222_2222_22d2, 64'hd3d3_3333_3333_33d3};
    g = '{0, 1, 0, 2};
    run_write(32'hdead_beef, d, g, 1'b0);
  endtask

  task automatic test_stalled_read();
    beats_t b;
    gaps_t g;
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    g = '{0, 2, 0, 1};
    run_read(32'h8000_0040, b, g, 1'b0);
  endtask

  task automatic test_hold_through_done();
    beats_t b;
    gaps_t g;
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    g = '{0, 0, 1, 0};
    run_read(32'h0000_2000, b, g, 1'b1);
    @(negedge clk);
    pmem_read = 1'b0;
    n_checks++;
    if (read_o !== 1'b0 || adaptor_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_reaccept: rd=%b resp=%b want 0 0",
               read_o, adaptor_resp);
    end
    @(negedge clk);
    n_checks++;
    if (read_o !== 1'b0 || write_o !== 1'b0 || adaptor_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: rd=%b wr=%b resp=%b want 0",
               read_o, write_o, adaptor_resp);
    end
  endtask

  task automatic test_back_to_back();
    beats_t b;
    gaps_t g;
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    g = '{0, 0, 0, 0};
    run_read(32'h0000_3000, b, g, 1'b0);
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    run_read(32'h0000_3020, b, g, 1'b0);
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    run_write(32'h0000_3040, b, g, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    beats_t d;
    beats_t b;
    gaps_t g;
    for (int i = 0; i < 4; i++) d[i] = rnd64();
    @(negedge clk);
    pmem_write = 1'b1;
    address_i = 32'h0000_5000;
    line_i = {d[3], d[2], d[1], d[0]};
    @(negedge clk);
    pmem_write = 1'b0;
    resp_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resp_i = 1'b0;
    n_checks++;
    if (burst_o !== d[2] || write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_beat: burst=%h wr=%b want %h 1",
               burst_o, write_o, d[2]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (write_o !== 1'b0 || adaptor_resp !== 1'b0 || address_o !== '0) begin
      n_fail++;
      $display("FAIL async_rst: wr=%b resp=%b addr=%h want 0",
               write_o, adaptor_resp, address_o);
    end
    last_line = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (adaptor_resp !== 1'b0 || write_o !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst_idle: resp=%b wr=%b want 0",
                 adaptor_resp, write_o);
      end
    end
    for (int i = 0; i < 4; i++) b[i] = rnd64();
    g = '{1, 0, 0, 0};
    run_read(32'h0000_6010, b, g, 1'b0);
  endtask

  task automatic test_simultaneous();
    beats_t d;
    gaps_t g;
    for (int i = 0; i < 4; i++) d[i] = rnd64();
    g = '{0, 0, 0, 0};
    run_write(32'h0000_7000, d, g, 1'b1);
  endtask

  task automatic test_random();
    beats_t b;
    gaps_t g;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) begin
        b[i] = rnd64();
        g[i] = int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        run_write($urandom, b, g, 1'($urandom_range(0, 1)));
      else
        run_read($urandom, b, g, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_read_b2b();
    test_write();
    test_stalled_read();
    test_hold_through_done();
    test_back_to_back();
    test_reset_mid_write();
    test_simultaneous();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
